sram_arbiter_ctrl: RTL

Parametrised, multi-client controller for the board's asynchronous SRAM (16-bit, 1M-word part by default). It arbitrates NUM_PORTS bridge-style conduits round-robin and runs one SRAM cycle at a time with programmable read/write wait states. It drives the SRAM pins with registered, glitch-free strobes. It sits between the Avalon/conduit clients (video, filter, DMA) and the external SRAM pins.

---
 rtl/sram_ctrl_pkg.sv | 22 ++
 rtl/sram_rr_arbiter.sv | 34 +++
 rtl/sram_arbiter_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM arbiter/controller: FSM encoding, default
// parameter values and the port-index width helper.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ADDR_W    = 20;
  localparam int DEF_NUM_PORTS = 2;
  localparam int DEF_RD_WAIT   = 1;
  localparam int DEF_WR_WAIT   = 1;

  // A single port still needs a 1-bit index so every index vector stays legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_rr_arbiter.sv
// Combinational round-robin arbiter: searches from the port after last_grant
// and returns a one-hot grant plus its encoded index.
module sram_rr_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter  int NUM_PORTS = DEF_NUM_PORTS,
  localparam int IDX_W     = idx_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last_grant,
  input  logic                 enable,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_PORTS);
      if (enable && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter_ctrl.sv
// Multi-client asynchronous SRAM controller: round-robin arbitration, one SRAM
// cycle at a time with programmable wait states, all SRAM pins from flops.
module sram_arbiter_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int ADDR_W    = DEF_ADDR_W,
  parameter  int NUM_PORTS = DEF_NUM_PORTS,
  parameter  int RD_WAIT   = DEF_RD_WAIT,
  parameter  int WR_WAIT   = DEF_WR_WAIT,
  localparam int BE_W      = DATA_W / 8,
  localparam int IDX_W     = idx_w(NUM_PORTS),
  localparam int AW1       = ADDR_W + 1
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic [NUM_PORTS*AW1-1:0]      bridge_input_conduit_address,
  input  logic [NUM_PORTS*BE_W-1:0]     bridge_input_conduit_byte_enable,
  input  logic [NUM_PORTS-1:0]          bridge_input_conduit_read,
  input  logic [NUM_PORTS-1:0]          bridge_input_conduit_write,
  input  logic [NUM_PORTS*DATA_W-1:0]   bridge_input_conduit_write_data,
  output logic [NUM_PORTS-1:0]          bridge_input_conduit_acknowledge,
  output logic [NUM_PORTS*DATA_W-1:0]   bridge_input_conduit_read_data,
  inout  wire  [DATA_W-1:0]             sram_conduit_DQ,
  output logic [ADDR_W-1:0]             sram_conduit_ADDR,
  output logic [BE_W-1:0]               sram_conduit_BE_N,
  output logic                          sram_conduit_CE_N,
  output logic                          sram_conduit_OE_N,
  output logic                          sram_conduit_WE_N
);

  state_e                state_q, state_d;
  logic [3:0]            wait_q, wait_d;
  logic [IDX_W-1:0]      idx_q, idx_d, last_grant_q, last_grant_d, grant_idx;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [BE_W-1:0]       be_q, be_d, be_n_q, be_n_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  is_wr_q, is_wr_d, dq_oe_q, dq_oe_d, rd_sample;
  logic                  ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic [NUM_PORTS-1:0]  ack_q, ack_d, port_req, grant, idx_onehot;
  logic [NUM_PORTS-1:0]  unused_addr_lsb;
  logic [ADDR_W-1:0]     port_addr  [NUM_PORTS];
  logic [BE_W-1:0]       port_be    [NUM_PORTS];
  logic [DATA_W-1:0]     port_wdata [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    logic [DATA_W-1:0] rdata_q, rdata_d;

    assign port_req[g]        = bridge_input_conduit_read[g] | bridge_input_conduit_write[g];
    assign port_addr[g]       = bridge_input_conduit_address[g*AW1+1 +: ADDR_W];
    assign unused_addr_lsb[g] = bridge_input_conduit_address[g*AW1];
    assign port_be[g]         = bridge_input_conduit_byte_enable[g*BE_W +: BE_W];
    assign port_wdata[g]      = bridge_input_conduit_write_data[g*DATA_W +: DATA_W];
    assign idx_onehot[g]      = (idx_q == IDX_W'(g));

    always_comb begin
      rdata_d = rdata_q;
      if (rd_sample && idx_onehot[g]) rdata_d = sram_conduit_DQ;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) rdata_q <= '0;
      else                rdata_q <= rdata_d;
    end

    assign bridge_input_conduit_read_data[g*DATA_W +: DATA_W] = rdata_q;
  end

  sram_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .req        (port_req),
    .last_grant (last_grant_q),
    .enable     (state_q == IDLE),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // Pin values are computed for the next cycle so every strobe leaves a flop.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    is_wr_d      = is_wr_q;
    last_grant_d = last_grant_q;
    ack_d        = '0;
    ce_n_d       = 1'b1;
    oe_n_d       = 1'b1;
    we_n_d       = 1'b1;
    be_n_d       = '1;
    dq_oe_d      = 1'b0;
    rd_sample    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|grant) begin
          idx_d   = grant_idx;
          addr_d  = port_addr[grant_idx];
          be_d    = port_be[grant_idx];
          wdata_d = port_wdata[grant_idx];
          is_wr_d = bridge_input_conduit_write[grant_idx];
          wait_d  = is_wr_d ? 4'(WR_WAIT) : 4'(RD_WAIT);
          state_d = ACCESS;
          ce_n_d  = 1'b0;
          oe_n_d  = is_wr_d;
          we_n_d  = !is_wr_d;
          be_n_d  = is_wr_d ? ~be_d : '0;
          dq_oe_d = is_wr_d;
        end
      end
      ACCESS: begin
        dq_oe_d = is_wr_q;
        if (wait_q == '0) begin
          state_d   = DONE;
          ack_d     = idx_onehot;
          rd_sample = !is_wr_q;
        end else begin
          wait_d = wait_q - 4'd1;
          ce_n_d = 1'b0;
          oe_n_d = is_wr_q;
          we_n_d = !is_wr_q;
          be_n_d = is_wr_q ? ~be_q : '0;
        end
      end
      DONE: begin
        state_d      = IDLE;
        last_grant_d = idx_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q      <= IDLE;
      wait_q       <= '0;
      idx_q        <= '0;
      addr_q       <= '0;
      is_wr_q      <= 1'b0;
      last_grant_q <= IDX_W'(NUM_PORTS - 1);
      ack_q        <= '0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      be_n_q       <= '1;
      dq_oe_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      is_wr_q      <= is_wr_d;
      last_grant_q <= last_grant_d;
      ack_q        <= ack_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      be_n_q       <= be_n_d;
      dq_oe_q      <= dq_oe_d;
    end
  end

  // Write payload only matters while dq_oe_q / the write strobe qualify it.
  always_ff @(posedge clk_clk) begin
    be_q    <= be_d;
    wdata_q <= wdata_d;
  end

  assign sram_conduit_DQ                  = dq_oe_q ? wdata_q : {DATA_W{1'bz}};
  assign sram_conduit_ADDR                = addr_q;
  assign sram_conduit_BE_N                = be_n_q;
  assign sram_conduit_CE_N                = ce_n_q;
  assign sram_conduit_OE_N                = oe_n_q;
  assign sram_conduit_WE_N                = we_n_q;
  assign bridge_input_conduit_acknowledge = ack_q;

endmodule
